// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, PC step and buffer entry type for the fetch unit
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INST_W   = 32;
  localparam int PC_INC   = 4;

  // Entry at the default address width; other widths rebuild the same layout locally.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - first-word-fall-through prefetch buffer with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(fetchEntry_t)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  assign headData = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) mem[tail] <= pushData;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction prefetch with redirect flush and stale-response drop
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = DEPTH[CW:0];

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetchPc, rspPc, redirectBase;
  logic [CW-1:0]   outstanding, dropCnt, count, owed;
  logic [CW:0]     inFlight;
  logic            started, reqFire, rspTaken, pushEn, popEn;
  entry_t          pushEntry, headEntry;
  logic [$bits(entry_t)-1:0] headData;

  assign redirectBase = redirect_pc & ~XLEN'(PC_INC - 1);
  assign inFlight     = {1'b0, count} + {1'b0, outstanding};

  // Requests only go out while buffer space is guaranteed for every reply.
  assign imem_req_valid = started && !redirect_valid && (inFlight < CREDITS);
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // A response with nothing owed is a protocol error and is ignored.
  assign rspTaken = imem_rsp_valid && (outstanding != '0);
  assign owed     = rspTaken ? outstanding - 1'b1 : outstanding;
  assign pushEn   = rspTaken && (dropCnt == '0) && !redirect_valid;
  assign popEn    = inst_valid && inst_ready && !redirect_valid;

  assign pushEntry = '{pc: rspPc, inst: imem_rsp_data};
  assign headEntry = headData;

  assign inst_valid = (count != '0);
  assign inst_data  = headEntry.inst;
  assign inst_pc    = headEntry.pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (reqFire && !rspTaken)      outstanding <= outstanding + 1'b1;
      else if (rspTaken && !reqFire) outstanding <= outstanding - 1'b1;
      // Everything still owed after a redirect belongs to the old path.
      if (redirect_valid) begin
        fetchPc <= redirectBase;
        rspPc   <= redirectBase;
        dropCnt <= owed;
      end else begin
        if (reqFire) fetchPc <= fetchPc + XLEN'(PC_INC);
        if (pushEn)  rspPc   <= rspPc + XLEN'(PC_INC);
        if (rspTaken && (dropCnt != '0)) dropCnt <= dropCnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .flush    (redirect_valid),
    .push     (pushEn),
    .pushData (pushEntry),
    .pop      (popEn),
    .headData (headData),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a latency-programmable memory model
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK            (clk),
    .RST_N          (RST_N),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lat = 1;
  int reqCount = 0;
  int popCount = 0;
  bit checkAddr = 0;
  bit injectRsp = 0;
  logic [31:0] expQ[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] pAddr[$];
  int          pDue[$];
  logic [31:0] monPc, monData, rspWord;
  int t0, t1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory: capture handshakes away from the edge, reply in order after lat cycles.
  always @(negedge clk) begin
    if (RST_N && imem_req_valid && imem_req_ready) begin
      reqCount++;
      pAddr.push_back(imem_req_addr);
      pDue.push_back(cycle + lat);
      if (checkAddr && expAddrQ.size() > 0) check("req_addr", imem_req_addr, expAddrQ.pop_front());
    end
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      imem_rsp_valid = 1'b0;
      if (injectRsp) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        injectRsp      = 1'b0;
      end else if (pDue.size() > 0 && pDue[0] <= cycle) begin
        rspWord        = pAddr.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~rspWord;
        void'(pDue.pop_front());
      end
    end
  end

  // Monitor: every consumed instruction must be the next expected one.
  always @(negedge clk) begin
    if (RST_N && !redirect_valid && inst_valid && inst_ready) begin
      popCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual_pc=%0h required=none", inst_pc);
      end else begin
        monPc   = expQ.pop_front();
        monData = ~monPc;
        check("inst_pc", inst_pc, monPc);
        check("inst_data", inst_data, monData);
      end
    end
  end

  task automatic doReset();
    RST_N = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reqCount = 0;
    popCount = 0;
    RST_N = 1'b1;
  endtask

  task automatic waitReq(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (reqCount >= n) break;
    end
    check("wait_req", reqCount >= n, 1);
  endtask

  task automatic drainWait(input string name, input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);

    // Streaming at latency 1: sequential addresses, one instruction per cycle.
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      expQ.push_back(32'(i * 4));
      expAddrQ.push_back(32'(i * 4));
    end
    checkAddr = 1; inst_ready = 1'b1;
    doReset();
    t0 = -1; t1 = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (popCount >= 1 && t0 < 0) t0 = k;
      if (popCount >= 8) begin t1 = k; break; end
    end
    inst_ready = 1'b0; checkAddr = 0;
    check("t1_stream_cycles", t1 - t0, 7);
    check("t1_sb_empty", expQ.size() + expAddrQ.size(), 0);

    // Decode stalled: credit limit of 4, one pop frees exactly one request.
    lat = 1; inst_ready = 1'b0;
    doReset();
    repeat (10) begin @(posedge clk); #1; end
    check("t2_req_count", reqCount, 4);
    @(negedge clk);
    check("t2_req_stalled", imem_req_valid, 0);
    expQ.push_back(32'h0); expAddrQ.push_back(32'h10); checkAddr = 1;
    @(posedge clk); #1; inst_ready = 1'b1;
    @(posedge clk); #1; inst_ready = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("t2_one_more_req", reqCount, 5);
    check("t2_sb_empty", expQ.size() + expAddrQ.size(), 0);
    checkAddr = 0;

    // Latency 3, redirect with three in flight: stale replies never surface.
    lat = 3; inst_ready = 1'b1;
    expQ.push_back(32'h100); expQ.push_back(32'h104); expQ.push_back(32'h108);
    doReset();
    waitReq(3, 20);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1; redirect_valid = 1'b0;
    drainWait("t3_drain", 60);
    inst_ready = 1'b0;

    // Redirect colliding with a response and a pop at count 2; unaligned target.
    lat = 1; inst_ready = 1'b0;
    doReset();
    waitReq(3, 20);
    check("t4_pre_valid", inst_valid, 1);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
    expQ.push_back(32'h100); expQ.push_back(32'h104);
    expAddrQ.push_back(32'h100); expAddrQ.push_back(32'h104); checkAddr = 1;
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_flushed", inst_valid, 0);
    check("t4_aligned_addr", imem_req_addr, 32'h100);
    drainWait("t4_drain", 40);
    inst_ready = 1'b0; checkAddr = 0; expAddrQ.delete();

    // Address wrap past the top of the space.
    @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1; redirect_valid = 1'b0;
    expQ.push_back(32'hFFFF_FFFC); expQ.push_back(32'h0); expQ.push_back(32'h4);
    expAddrQ.push_back(32'hFFFF_FFFC); expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h4);
    checkAddr = 1; inst_ready = 1'b1;
    drainWait("t4_wrap_drain", 40);
    inst_ready = 1'b0; checkAddr = 0;
    check("t4_wrap_addr_done", expAddrQ.size(), 0);

    // Asynchronous reset mid-flight; late replies land while reset is held.
    lat = 3; inst_ready = 1'b0;
    doReset();
    waitReq(4, 20);
    @(posedge clk); #1;
    check("t5_pre_valid", inst_valid, 1);
    #3; RST_N = 1'b0;
    #1;
    check("t5_async_inst_valid", inst_valid, 0);
    check("t5_async_req_valid", imem_req_valid, 0);
    expQ.push_back(32'h0); expQ.push_back(32'h4); expQ.push_back(32'h8);
    expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h4); expAddrQ.push_back(32'h8);
    checkAddr = 1; inst_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1; reqCount = 0; popCount = 0; RST_N = 1'b1;
    drainWait("t5_drain", 40);
    inst_ready = 1'b0; checkAddr = 0;
    check("t5_addr_done", expAddrQ.size(), 0);

    // Response with nothing outstanding is ignored and leaves credits intact.
    lat = 1; imem_req_ready = 1'b0; inst_ready = 1'b0;
    doReset();
    @(posedge clk); #1; injectRsp = 1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t6_no_push", inst_valid, 0);
    check("t6_req_pending", imem_req_valid, 1);
    check("t6_req_addr", imem_req_addr, 32'h0);
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    inst_ready = 1'b1; imem_req_ready = 1'b1;
    drainWait("t6_drain", 30);
    inst_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
